// File: rtl/uart_tx_unpacker_if.sv
// uart_tx_unpacker_if: producer-side load/status and TX-core handshake bundle.
// Rev 1.0
`default_nettype none

interface uart_tx_unpacker_if #(
  parameter int DATA_SIZE  = 8,
  parameter int WORD_COUNT = 4
);
  localparam int CW = $clog2(WORD_COUNT + 1);

  logic                            load;
  logic [DATA_SIZE*WORD_COUNT-1:0] load_data;
  logic [CW-1:0]                   load_count;
  logic                            abort;
  logic                            tx_done;
  logic                            tx_start;
  logic [DATA_SIZE-1:0]            tx_data;
  logic                            busy;
  logic [CW-1:0]                   remaining;
  logic                            done;

  modport slave (
    input  load, load_data, load_count, abort, tx_done,
    output tx_start, tx_data, busy, remaining, done
  );

  modport master (
    output load, load_data, load_count, abort, tx_done,
    input  tx_start, tx_data, busy, remaining, done
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_unpacker.sv
// uart_tx_unpacker: drains a packed word to the UART TX core, top byte first.
// Rev 1.0
`default_nettype none

module uart_tx_unpacker #(
  parameter int DATA_SIZE  = 8,
  parameter int WORD_COUNT = 4
) (
  input  logic                clk,
  input  logic                reset,
  uart_tx_unpacker_if.slave   bus
);
  localparam int CW    = $clog2(WORD_COUNT + 1);
  localparam int WIDTH = DATA_SIZE * WORD_COUNT;
  localparam logic [CW-1:0] FULL_COUNT = CW'(WORD_COUNT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [WIDTH-1:0] shift_buf;
  logic [CW-1:0]   rem_count;
  logic            done_pulse;
  logic [CW-1:0]   norm_count;
  logic            last_byte;
  logic            start_comb;
  logic            busy_comb;

  // Zero or oversize counts mean "send the whole word".
  assign norm_count = ((bus.load_count == '0) || (bus.load_count > FULL_COUNT))
                      ? FULL_COUNT : bus.load_count;
  assign last_byte  = (rem_count == CW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shift_buf  <= '0;
      rem_count  <= '0;
      done_pulse <= 1'b0;
    end else begin
      state      <= state_next;
      done_pulse <= 1'b0;
      if (bus.abort) begin
        rem_count <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.load) begin
              shift_buf <= bus.load_data;
              rem_count <= norm_count;
            end
          end
          WAIT: begin
            if (bus.tx_done) begin
              // The final byte is left in place so tx_data holds it in IDLE.
              if (!last_byte) begin
                shift_buf <= shift_buf << DATA_SIZE;
              end
              rem_count  <= rem_count - CW'(1);
              done_pulse <= last_byte;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_next = state;
    start_comb = 1'b0;
    busy_comb  = (state != IDLE);
    case (state)
      IDLE: begin
        if (bus.load) begin
          state_next = SEND;
        end
      end
      SEND: begin
        start_comb = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (bus.tx_done) begin
          state_next = last_byte ? IDLE : SEND;
        end
      end
      default: state_next = IDLE;
    endcase
    if (bus.abort) begin
      state_next = IDLE;
      start_comb = 1'b0;
    end
  end

  assign bus.tx_start  = start_comb;
  assign bus.tx_data   = shift_buf[WIDTH-1 -: DATA_SIZE];
  assign bus.busy      = busy_comb;
  assign bus.remaining = rem_count;
  assign bus.done      = done_pulse;
endmodule

`default_nettype wire

// File: tb/tb_uart_tx_unpacker.sv
// tb_uart_tx_unpacker: directed checks of byte order, counts, abort, reset and back-to-back loads.
// Rev 1.0
`default_nettype none

module tb_uart_tx_unpacker;
  localparam int DATA_SIZE  = 8;
  localparam int WORD_COUNT = 4;
  localparam int CW         = $clog2(WORD_COUNT + 1);
  localparam int TX_LAT     = 10;
  localparam int BUDGET     = 300;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_tx_unpacker_if #(.DATA_SIZE(DATA_SIZE), .WORD_COUNT(WORD_COUNT)) bus ();

  uart_tx_unpacker #(.DATA_SIZE(DATA_SIZE), .WORD_COUNT(WORD_COUNT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic model_done = 1'b0;
  logic force_done = 1'b0;
  assign bus.tx_done = model_done | force_done;

  int n_compared   = 0;
  int n_mismatched = 0;
  int model_cnt    = 0;
  int start_cnt    = 0;
  int done_cnt     = 0;
  logic [7:0] sent[$];

  // TX core model and output monitor, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    model_done = 1'b0;
    if (model_cnt > 0) begin
      model_cnt = model_cnt - 1;
      if (model_cnt == 0) model_done = 1'b1;
    end
    if (bus.tx_start) begin
      sent.push_back(bus.tx_data);
      start_cnt = start_cnt + 1;
      model_cnt = TX_LAT;
    end
    if (bus.done) done_cnt = done_cnt + 1;
  end

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared = n_compared + 1;
    if (got !== exp) begin
      n_mismatched = n_mismatched + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_bytes(input string tag, input logic [63:0] word, input int n);
    check_value({tag, " count"}, 64'(sent.size()), 64'(n));
    for (int i = 0; i < n && i < sent.size(); i++)
      check_value($sformatf("%s byte%0d", tag, i), 64'(sent[i]),
                  (word >> (8 * (n - 1 - i))) & 64'hFF);
  endtask

  task automatic clear_log();
    sent.delete();
    start_cnt = 0;
    done_cnt  = 0;
  endtask

  task automatic load_word(input logic [31:0] data, input logic [CW-1:0] cnt);
    @(negedge clk);
    bus.load       = 1'b1;
    bus.load_data  = data;
    bus.load_count = cnt;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  // Leaves the caller at the negedge of the cycle in which done is high.
  task automatic wait_done(input string tag);
    int i;
    for (i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (bus.done) break;
    end
    if (i == BUDGET) check_value({tag, " done timeout"}, 64'd0, 64'd1);
    else             check_value({tag, " busy at done"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic wait_sent(input string tag, input int n);
    int i;
    for (i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (sent.size() >= n) break;
    end
    if (i == BUDGET) check_value({tag, " start timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    bus.load       = 1'b0;
    bus.load_data  = '0;
    bus.load_count = '0;
    bus.abort      = 1'b0;

    repeat (3) @(negedge clk);
    check_value("reset tx_start",  64'(bus.tx_start),  64'd0);
    check_value("reset tx_data",   64'(bus.tx_data),   64'd0);
    check_value("reset busy",      64'(bus.busy),      64'd0);
    check_value("reset remaining", 64'(bus.remaining), 64'd0);
    check_value("reset done",      64'(bus.done),      64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Full word, MSB first
    clear_log();
    load_word(32'hDEADBEEF, 3'd4);
    check_value("full first tx_data", 64'(bus.tx_data), 64'hDE);
    check_value("full busy", 64'(bus.busy), 64'd1);
    wait_done("full");
    @(negedge clk);
    check_value("full done drops", 64'(bus.done), 64'd0);
    check_value("full tx_data holds", 64'(bus.tx_data), 64'hEF);
    check_bytes("full", 64'hDEADBEEF, 4);
    check_value("full starts", 64'(start_cnt), 64'd4);
    check_value("full dones", 64'(done_cnt), 64'd1);

    // Partial count
    clear_log();
    load_word(32'h11223344, 3'd2);
    check_value("partial rem first", 64'(bus.remaining), 64'd2);
    wait_sent("partial", 2);
    check_value("partial rem second", 64'(bus.remaining), 64'd1);
    wait_done("partial");
    check_value("partial rem end", 64'(bus.remaining), 64'd0);
    check_bytes("partial", 64'h1122, 2);
    check_value("partial dones", 64'(done_cnt), 64'd1);

    // Normalized counts
    clear_log();
    load_word(32'hA1B2C3D4, 3'd0);
    check_value("count0 rem", 64'(bus.remaining), 64'd4);
    wait_done("count0");
    check_bytes("count0", 64'hA1B2C3D4, 4);
    clear_log();
    load_word(32'h5A6B7C8D, 3'd7);
    check_value("count7 rem", 64'(bus.remaining), 64'd4);
    wait_done("count7");
    check_bytes("count7", 64'h5A6B7C8D, 4);

    // Load while busy is ignored
    clear_log();
    load_word(32'hDEADBEEF, 3'd4);
    repeat (3) @(negedge clk);
    bus.load = 1'b1; bus.load_data = 32'hCAFEF00D; bus.load_count = 3'd4;
    @(negedge clk);
    bus.load = 1'b0;
    wait_done("busyload");
    check_bytes("busyload", 64'hDEADBEEF, 4);
    check_value("busyload dones", 64'(done_cnt), 64'd1);

    // tx_done in IDLE
    repeat (3) @(negedge clk);
    clear_log();
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    repeat (3) @(negedge clk);
    check_value("idle txdone busy", 64'(bus.busy), 64'd0);
    check_value("idle txdone starts", 64'(start_cnt), 64'd0);
    check_value("idle txdone rem", 64'(bus.remaining), 64'd0);

    // tx_done during the SEND cycle
    clear_log();
    load_word(32'h0A0B0C0D, 3'd4);
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    check_value("send txdone rem", 64'(bus.remaining), 64'd4);
    check_value("send txdone start", 64'(bus.tx_start), 64'd0);
    wait_done("send txdone");
    check_bytes("send txdone", 64'h0A0B0C0D, 4);

    // Abort while waiting on the second byte
    clear_log();
    load_word(32'hDEADBEEF, 3'd4);
    wait_sent("abort", 2);
    repeat (2) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check_value("abort busy", 64'(bus.busy), 64'd0);
    check_value("abort rem", 64'(bus.remaining), 64'd0);
    repeat (20) @(negedge clk);
    check_value("abort starts", 64'(start_cnt), 64'd2);
    check_value("abort dones", 64'(done_cnt), 64'd0);
    clear_log();
    load_word(32'h01020304, 3'd4);
    wait_done("after abort");
    check_bytes("after abort", 64'h01020304, 4);

    // Reset during the third byte
    clear_log();
    load_word(32'hDEADBEEF, 3'd4);
    wait_sent("midreset", 3);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_value("midreset tx_start",  64'(bus.tx_start),  64'd0);
    check_value("midreset tx_data",   64'(bus.tx_data),   64'd0);
    check_value("midreset busy",      64'(bus.busy),      64'd0);
    check_value("midreset remaining", 64'(bus.remaining), 64'd0);
    check_value("midreset done",      64'(bus.done),      64'd0);
    repeat (20) @(negedge clk);
    check_value("midreset starts", 64'(start_cnt), 64'd3);
    check_value("midreset dones", 64'(done_cnt), 64'd0);

    // Back-to-back load in the done cycle
    clear_log();
    load_word(32'h55667788, 3'd4);
    wait_done("b2b first");
    bus.load = 1'b1; bus.load_data = 32'h99AABBCC; bus.load_count = 3'd4;
    @(negedge clk);
    bus.load = 1'b0;
    check_value("b2b tx_start", 64'(bus.tx_start), 64'd1);
    check_value("b2b tx_data", 64'(bus.tx_data), 64'h99);
    wait_done("b2b second");
    check_bytes("b2b", 64'h5566778899AABBCC, 8);
    check_value("b2b dones", 64'(done_cnt), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule

`default_nettype wire
